// File: rtl/palindrome_pkg.sv
// Shared constants for the palindrome stream generator and detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package palindrome_pkg;

  // Digit geometry
  localparam int DIGIT_W     = 4;
  localparam int MAX_DIGITS  = 16;
  localparam int SEED_DIGITS = 8;
  localparam int LEN_W       = 5;
  localparam int SEED_W      = SEED_DIGITS * DIGIT_W;
  localparam int SEQ_W       = MAX_DIGITS * DIGIT_W;

  // Sequencer states, kept as plain constants so legacy blocks can share them
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Applied to the final digit in corrupt mode so first != last
  localparam logic [DIGIT_W-1:0] CORRUPT_MASK = 4'h1;

  // Request captured when a start is accepted
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [SEED_W-1:0] seed;
    logic              mode;
  } req_t;

  // A length is usable when it names at least one digit and fits the word
  function automatic logic len_is_valid(input logic [LEN_W-1:0] l);
    return (l != '0) && (l <= LEN_W'(MAX_DIGITS));
  endfunction

endpackage

// File: rtl/palindrome_stream_gen_if.sv
// Digit stream between generator (master) and detector A input (slave).
// Latency: wires only.
// Backpressure: a_ready from slave; master holds a_valid/a_data until taken.
interface palindrome_stream_gen_if;
  import palindrome_pkg::*;

  logic               a_valid;
  logic               a_ready;
  logic [DIGIT_W-1:0] a_data;

  modport master (output a_valid, output a_data, input a_ready);
  modport slave  (input a_valid, input a_data, output a_ready);

endinterface

// File: rtl/palin_digit_sel.sv
// Maps a digit position to its value: seed half, mirrored half, optional corruption.
// Latency: combinational.
// Backpressure: none; caller holds index steady while stalled.
module palin_digit_sel
  import palindrome_pkg::*;
(
  input  req_t               req,
  input  logic [LEN_W-1:0]   index,
  output logic [DIGIT_W-1:0] digit
);

  logic [LEN_W:0]     len_p1;
  logic [LEN_W-1:0]   half;
  logic [LEN_W-1:0]   src;
  logic [DIGIT_W-1:0] raw;
  logic               is_last;

  // Resolve which seed digit feeds this position and apply corruption
  always_comb begin
    len_p1  = {1'b0, req.len} + {{LEN_W{1'b0}}, 1'b1};
    half    = len_p1[LEN_W:1];
    // Positions past the midpoint mirror back onto the seed half
    if (index < half) begin
      src = index;
    end else begin
      src = req.len - LEN_W'(1) - index;
    end
    raw = '0;
    for (int i = 0; i < SEED_DIGITS; i++) begin
      if (src == LEN_W'(i)) begin
        raw = req.seed[SEED_W-1-i*DIGIT_W -: DIGIT_W];
      end
    end
    is_last = (index == req.len - LEN_W'(1));
    // A single-digit sequence is its own mirror, so it is never corrupted
    if (req.mode && (req.len >= LEN_W'(2)) && is_last) begin
      digit = raw ^ CORRUPT_MASK;
    end else begin
      digit = raw;
    end
  end

endmodule

// File: rtl/palindrome_stream_gen.sv
// Expands a half seed into a palindrome (or near-miss) and streams it MSB-first.
// Latency: first beat 1 cycle after accepted start; done 1 cycle after last beat.
// Backpressure: holds a_valid/a_data while a_ready is low; start ignored while busy.
module palindrome_stream_gen
  import palindrome_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [SEED_W-1:0]     seed,
  input  logic                  mode,
  palindrome_stream_gen_if.master a_if,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SEQ_W-1:0]      seq_out
);

  logic [1:0]         state;
  req_t               req_q;
  logic [LEN_W-1:0]   index;
  logic               err_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [DIGIT_W-1:0] digit;
  logic               sending;
  logic               xfer;
  logic               accept;
  logic               reject;
  logic               last_beat;

  palin_digit_sel u_digit_sel (
    .req   (req_q),
    .index (index),
    .digit (digit)
  );

  // Decode handshake and request qualification
  always_comb begin
    sending   = (state == ST_SEND);
    xfer      = sending && a_if.a_ready;
    accept    = (state == ST_IDLE) && start && len_is_valid(len);
    reject    = (state == ST_IDLE) && start && !len_is_valid(len);
    last_beat = (index == req_q.len - LEN_W'(1));
  end

  // Sequencer: IDLE -> SEND on a good start, SEND -> DONE on the last beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_SEND;
        ST_SEND: if (xfer && last_beat) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request once so later input changes cannot disturb the stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= '{len: len, seed: seed, mode: mode};
    end
  end

  // Digit position: restarts on accept, steps on every transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= '0;
    end else if (accept) begin
      index <= '0;
    end else if (xfer) begin
      index <= index + LEN_W'(1);
    end
  end

  // Assemble emitted digits MSB-aligned; held through IDLE until the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q <= '0;
    end else if (accept) begin
      seq_q <= '0;
    end else if (xfer) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if (index == LEN_W'(i)) begin
          seq_q[SEQ_W-1-i*DIGIT_W -: DIGIT_W] <= digit;
        end
      end
    end
  end

  // One-cycle error flag for a start carrying an unusable length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
    end
  end

  // Outputs are straight decodes of registered state
  always_comb begin
    a_if.a_valid = sending;
    a_if.a_data  = sending ? digit : '0;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    err          = err_q;
    seq_out      = seq_q;
  end

endmodule

// File: tb/tb_palindrome_stream_gen.sv
// Directed bench: scoreboard of expected digits, immediate-assert checks.
// Latency: checks first beat at T+1 and done at T+len+1 with ready held high.
// Backpressure: exercises stalled ready patterns and stability across stalls.
module tb_palindrome_stream_gen;
  import palindrome_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [SEED_W-1:0] seed;
  logic              mode;
  logic              busy;
  logic              done;
  logic              err;
  logic [SEQ_W-1:0]  seq_out;

  int total;
  int bad;
  logic [3:0] exp_q[$];

  palindrome_stream_gen_if a_if ();

  palindrome_stream_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .seed    (seed),
    .mode    (mode),
    .a_if    (a_if.master),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .seq_out (seq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference digit value from the sequence definition
  function automatic logic [3:0] ref_digit(input int l, input logic [31:0] s,
                                          input logic m, input int i);
    int h;
    int j;
    logic [31:0] sh;
    logic [3:0] d;
    h  = (l + 1) / 2;
    j  = (i < h) ? i : (l - 1 - i);
    sh = s >> (28 - 4 * j);
    d  = sh[3:0];
    if (m && l >= 2 && i == l - 1) d = d ^ 4'h1;
    return d;
  endfunction

  // Issue a start and walk the stream to done against the scoreboard
  task automatic run_stream(input int l, input logic [31:0] s, input logic m,
                            input logic [5:0] rpat, input int rpat_n,
                            input logic [63:0] exp_seq, input bit poke);
    int cyc;
    int k;
    int xfers;
    bit seen_done;
    bit prev_stall;
    logic [3:0] prev_data;
    logic [3:0] e;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(l); seed = s; mode = m;
    for (int i = 0; i < l; i++) exp_q.push_back(ref_digit(l, s, m, i));
    cyc = 0; k = 0; xfers = 0; seen_done = 0; prev_stall = 0; prev_data = '0;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        len   = 5'd9;
        seed  = 32'hDEADBEEF;
        mode  = ~m;
        chk("first_beat_valid", 64'(a_if.a_valid), 64'd1);
        chk("first_beat_busy", 64'(busy), 64'd1);
      end
      if (poke && cyc == 3) begin
        start = 1'b1; len = 5'd3; seed = 32'hFFFFFFFF;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(a_if.a_valid), 64'd1);
        chk("stall_data_hold", 64'(a_if.a_data), 64'(prev_data));
      end
      if (done) begin
        seen_done = 1;
        chk("done_xfer_count", 64'(xfers), 64'(l));
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_valid_low", 64'(a_if.a_valid), 64'd0);
        chk("seq_out", seq_out, exp_seq);
        if (rpat_n == 1 && rpat[0]) chk("done_cycle", 64'(cyc), 64'(l + 1));
      end else begin
        if (xfers < l) chk("valid_until_last", 64'(a_if.a_valid), 64'd1);
        a_if.a_ready = rpat[k % rpat_n];
        k++;
        prev_stall = a_if.a_valid && !a_if.a_ready;
        prev_data  = a_if.a_data;
        if (a_if.a_valid && a_if.a_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(a_if.a_data), 64'(e));
          end
          xfers++;
        end
      end
    end
    if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
    a_if.a_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_seq_hold", seq_out, exp_seq);
    exp_q.delete();
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; len = '0; seed = '0; mode = 1'b0;
    a_if.a_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(a_if.a_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_seq", seq_out, 64'd0);
    #20 reset = 1'b0;

    // Odd palindrome, ready always high
    run_stream(5, 32'h12300000, 1'b0, 6'b000001, 1, 64'h1232100000000000, 0);
    // Even palindrome
    run_stream(4, 32'hAB000000, 1'b0, 6'b000001, 1, 64'hABBA000000000000, 0);
    // Corrupt mode flips the last digit
    run_stream(5, 32'h12300000, 1'b1, 6'b000001, 1, 64'h1232000000000000, 0);
    // Single digit is never corrupted
    run_stream(1, 32'h70000000, 1'b1, 6'b000001, 1, 64'h7000000000000000, 0);
    // Full length with stalls 1,0,0,1,0,1 and an ignored start mid-stream
    run_stream(16, 32'h0123456F, 1'b0, 6'b101001, 6, 64'h0123456FF6543210, 1);

    // Invalid lengths: zero and one past the maximum
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; len = (t == 0) ? 5'd0 : 5'd17;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_no_valid", 64'(a_if.a_valid), 64'd0);
      chk("err_no_busy", 64'(busy), 64'd0);
      chk("err_seq_hold", seq_out, 64'h0123456FF6543210);
      @(negedge clk);
      chk("err_clears", 64'(err), 64'd0);
      chk("err_no_done", 64'(done), 64'd0);
    end

    // Reset in the middle of a stream after two beats
    @(negedge clk);
    start = 1'b1; len = 5'd5; seed = 32'h12300000; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 64'(a_if.a_valid), 64'd1);
    chk("pre_rst_seq", seq_out, 64'h1200000000000000);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_if.a_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_seq", seq_out, 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_stream(4, 32'hAB000000, 1'b0, 6'b000001, 1, 64'hABBA000000000000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
